sha256_wsched_ctrl: RTL and testbench

Synchronous sequencer for the SHA-256 message-schedule datapath. It accepts the 16 message words of one block and emits W[0..ROUNDS-1] in order on a valid/ready channel. Words 0..15 pass through; words 16.. are expanded from a 16-word sliding window using sigma0/sigma1. It sits between the block loader and the compression round engine and replaces the counter-driven ring for clocked builds.

---
 rtl/sha256_wsched_pkg.sv | 21 ++
 rtl/sha256_wsched_ctrl_wnext.sv | 14 +
 rtl/sha256_wsched_ctrl.sv | 149 ++++++++++++++
 tb/tb_sha256_wsched_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_wsched_pkg.sv
// Shared types and sigma functions for the SHA-256 message-schedule sequencer.
package sha256_wsched_pkg;

    localparam int unsigned WORDW = 32;
    localparam int unsigned WIN   = 16;

    typedef enum logic [1:0] {
        StLoad,
        StExpand,
        StDrain
    } state_e;

    function automatic logic [WORDW-1:0] sigma0(input logic [WORDW-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORDW-1:0] sigma1(input logic [WORDW-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_wsched_ctrl_wnext.sv
// Combinational expansion of the next schedule word from four window taps.
module sched_wnext
    import sha256_wsched_pkg::*;
(
    input  logic [WORDW-1:0] w0,
    input  logic [WORDW-1:0] w1,
    input  logic [WORDW-1:0] w9,
    input  logic [WORDW-1:0] w14,
    output logic [WORDW-1:0] wn
);

    assign wn = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_wsched_ctrl.sv
// Message-schedule sequencer: loads 16 words, expands to ROUNDS words on a
// single registered valid/ready output entry.
module sha256_wsched_ctrl
    import sha256_wsched_pkg::*;
#(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDXW   = 6
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WORDW-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORDW-1:0] out_word,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam logic [IDXW-1:0] LastIdx = IDXW'(ROUNDS - 1);
    localparam logic [IDXW-1:0] LoadEnd = IDXW'(WIN - 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   t_q, t_d;
    logic [WORDW-1:0]  win_q [WIN];
    logic [WORDW-1:0]  win_d [WIN];
    logic              out_valid_q, out_valid_d;
    logic [WORDW-1:0]  out_word_q, out_word_d;
    logic [IDXW-1:0]   out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              slot_free;
    logic              wr;
    logic [WORDW-1:0]  wr_word;
    logic [WORDW-1:0]  wn;

    sched_wnext u_wnext (
        .w0  (win_q[0]),
        .w1  (win_q[1]),
        .w9  (win_q[9]),
        .w14 (win_q[14]),
        .wn  (wn)
    );

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;
        wr          = 1'b0;
        wr_word     = '0;

        // Entry consumed with nothing to replace it.
        if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            StLoad: begin
                in_ready = slot_free && !flush;
                if (in_valid && in_ready) begin
                    wr      = 1'b1;
                    wr_word = in_word;
                    if (t_q == LoadEnd) begin
                        state_d = StExpand;
                    end
                end
            end
            StExpand: begin
                if (slot_free) begin
                    wr      = 1'b1;
                    wr_word = wn;
                    if (t_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_valid_q && out_ready) begin
                    t_d     = '0;
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase

        if (wr) begin
            for (int unsigned k = 0; k < WIN - 1; k++) begin
                win_d[k] = win_q[k+1];
            end
            win_d[WIN-1] = wr_word;
            out_valid_d  = 1'b1;
            out_word_d   = wr_word;
            out_idx_d    = t_q;
            out_last_d   = (t_q == LastIdx);
            // Parking t at 0 after the last word keeps it in range for ROUNDS == 2^IDXW.
            t_d          = (t_q == LastIdx) ? '0 : t_q + IDXW'(1);
        end

        if (flush) begin
            state_d     = StLoad;
            t_d         = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            for (int unsigned k = 0; k < WIN; k++) begin
                win_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= StLoad;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            for (int unsigned k = 0; k < WIN; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == StExpand) || ((state_q == StLoad) && (t_q != '0));

endmodule

// File: tb/tb_sha256_wsched_ctrl.sv
// Directed bench for sha256_wsched_ctrl: ROUNDS=64 instance plus a ROUNDS=17 instance.
module tb_sha256_wsched_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [31:0] in_word, out_word;
    logic [5:0]  out_idx;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b;
    logic [31:0] in_word_b, out_word_b;
    logic [4:0]  out_idx_b;

    sha256_wsched_ctrl #(.ROUNDS(64), .IDXW(6)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    sha256_wsched_ctrl #(.ROUNDS(17), .IDXW(5)) dut_b (
        .clk       (clk),
        .rst_      (rst_),
        .flush     (flush),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_word   (in_word_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_word  (out_word_b),
        .out_idx   (out_idx_b),
        .out_last  (out_last_b),
        .busy      (busy_b)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] blk   [16];
    logic [31:0] abc   [16];
    logic [31:0] blk2  [16];
    logic [31:0] expw  [64];
    logic [31:0] got   [64];
    logic [31:0] stream[32];
    logic [31:0] exp_b [34];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model();
        for (int i = 0; i < 16; i++) expw[i] = blk[i];
        for (int i = 16; i < 64; i++)
            expw[i] = s1(expw[i-2]) + expw[i-7] + s0(expw[i-15]) + expw[i-16];
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_word"},  64'(out_word),  64'(0));
        check({tag, "_idx"},   64'(out_idx),   64'(0));
        check({tag, "_last"},  64'(out_last),  64'(0));
        check({tag, "_busy"},  64'(busy),      64'(0));
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low for the first cycles.
    // abort_kind 1 flushes, 2 pulses async reset, once out_idx == abort_idx is seen.
    task automatic run_a(input int mode, input int abort_idx, input int abort_kind,
                         output int cycles);
        int          ptr, nxt, cyc;
        logic        stall, abort;
        logic [38:0] saved;
        ptr = 0; nxt = 0; cyc = 0; stall = 1'b0; abort = 1'b0; saved = '0;
        while (nxt < 64 && cyc < 3000 && !abort) begin
            @(negedge clk);
            cyc++;
            if (stall) check("stall_hold", 64'({out_word, out_idx, out_last}), 64'(saved));
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc > 6);
            endcase
            in_valid = 1'b1;
            in_word  = (ptr < 16) ? blk[ptr] : 32'hDEADBEEF;
            if (abort_idx >= 0 && out_valid && int'(out_idx) == abort_idx) begin
                abort = 1'b1;
                if (abort_kind == 1) begin
                    flush = 1'b1;
                end else begin
                    #2 rst_ = 1'b0;
                    #1 check_reset_vals("async_rst");
                end
            end
            #1;
            if (mode == 2 && cyc == 4) begin
                check("bp_in_ready", 64'(in_ready), 64'(0));
                check("bp_buffered", 64'(out_word), 64'(blk[0]));
                check("bp_one_taken", 64'(ptr), 64'(1));
            end
            if (!abort) begin
                if (in_valid && in_ready) begin
                    if (ptr < 16) ptr++;
                    else check("in_ignored", 64'(in_ready), 64'(0));
                end
                if (out_valid && out_ready) begin
                    check("idx", 64'(out_idx), 64'(nxt));
                    check("word", 64'(out_word), 64'(expw[nxt]));
                    check("last", 64'(out_last), 64'(nxt == 63));
                    got[nxt] = out_word;
                    nxt++;
                end
                stall = out_valid && !out_ready;
                saved = {out_word, out_idx, out_last};
            end
        end
        cycles = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        if (abort && abort_kind == 1) begin
            flush = 1'b0;
            #1;
            check("flush_valid", 64'(out_valid), 64'(0));
            check("flush_in_ready", 64'(in_ready), 64'(1));
            check("flush_busy", 64'(busy), 64'(0));
        end else if (abort) begin
            rst_ = 1'b1;
            #1 check_reset_vals("rst_release");
        end else begin
            if (nxt < 64) check("timeout", 64'(nxt), 64'(64));
            #1;
            check("reload_ready", 64'(in_ready), 64'(1));
            check("reload_valid", 64'(out_valid), 64'(0));
            check("reload_busy", 64'(busy), 64'(0));
        end
    endtask

    // Two blocks streamed back-to-back into the ROUNDS=17 instance.
    task automatic run_b();
        int ptr, nxt, cyc;
        ptr = 0; nxt = 0; cyc = 0;
        while (nxt < 34 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            out_ready_b = 1'b1;
            in_valid_b  = (ptr < 32);
            in_word_b   = (ptr < 32) ? stream[ptr] : 32'h0;
            #1;
            if (out_valid_b && out_idx_b == 5'd16) check("b_drain_no_in", 64'(in_ready_b), 64'(0));
            if (in_valid_b && in_ready_b) ptr++;
            if (out_valid_b && out_ready_b) begin
                check("b_idx", 64'(out_idx_b), 64'(nxt % 17));
                check("b_word", 64'(out_word_b), 64'(exp_b[nxt]));
                check("b_last", 64'(out_last_b), 64'((nxt % 17) == 16));
                nxt++;
            end
        end
        if (nxt < 34) check("b_timeout", 64'(nxt), 64'(34));
        @(negedge clk);
        in_valid_b = 1'b0;
        #1;
        check("b_reload_ready", 64'(in_ready_b), 64'(1));
        check("b_reload_valid", 64'(out_valid_b), 64'(0));
    endtask

    initial begin
        int cyc;
        rst_ = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
        in_valid_b = 1'b0; in_word_b = '0; out_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            abc[i]  = 32'h0;
            blk2[i] = 32'h01234567 * (i + 1) ^ 32'h9E3779B9;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        repeat (2) @(negedge clk);
        #1 check_reset_vals("reset");
        rst_ = 1'b1;
        #1 check("reset_in_ready", 64'(in_ready), 64'(1));

        // abc block, free-flowing output
        blk = abc;
        build_model();
        run_a(0, -1, 0, cyc);
        check("thruput_cycles", 64'(cyc), 64'(65));
        check("w16_abc", 64'(got[16]), 64'(32'h61626380));
        check("w17_abc", 64'(got[17]), 64'(32'h000F0000));

        run_a(1, -1, 0, cyc);
        run_a(2, -1, 0, cyc);

        // flush mid-expansion, then a different block
        run_a(0, 30, 1, cyc);
        blk = blk2;
        build_model();
        run_a(0, -1, 0, cyc);

        // async reset mid-block, then a fresh block
        blk = abc;
        build_model();
        run_a(1, 20, 2, cyc);
        run_a(0, -1, 0, cyc);
        check("w16_after_rst", 64'(got[16]), 64'(32'h61626380));

        // ROUNDS=17 instance, two blocks back-to-back
        blk = abc;
        build_model();
        for (int i = 0; i < 17; i++) exp_b[i] = expw[i];
        blk = blk2;
        build_model();
        for (int i = 0; i < 17; i++) exp_b[17 + i] = expw[i];
        for (int i = 0; i < 16; i++) begin
            stream[i]      = abc[i];
            stream[16 + i] = blk2[i];
        end
        run_b();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
